// File: rtl/ssd_arbiter.sv
// ssd_arbiter: round-robin time-sharing of the 8-digit seven-segment display among four sources.
// Latency: grant and display outputs are registered, valid one clock after the deciding edge.
// Backpressure: none; a waiting source holds req until granted, and an owner keeps the display while req stays high.
module ssd_arbiter #(
  parameter int DIV   = 50000,
  parameter int DWELL = 50000000,
  parameter int BLANK = 1000
) (
  input  logic         ssd_arbiter_clk,
  input  logic         ssd_arbiter_rst,
  input  logic [3:0]   ssd_arbiter_port_req,
  input  logic [127:0] ssd_arbiter_port_data,
  input  logic [31:0]  ssd_arbiter_port_en,
  input  logic [3:0]   ssd_arbiter_port_dp,
  output logic [3:0]   ssd_arbiter_port_gnt,
  output logic [31:0]  ssd_arbiter_port_inp,
  output logic [7:0]   ssd_arbiter_port_digit_en,
  output logic         ssd_arbiter_port_odp,
  output logic         ssd_arbiter_port_scan_clk,
  output logic         ssd_arbiter_port_busy
);

  // Counter widths are sized to hold the parameter value itself (never zero bits).
  localparam int SW  = $clog2(DIV + 1);
  localparam int DWW = $clog2(DWELL + 1);
  localparam int BW  = $clog2(BLANK + 1);

  localparam logic [SW-1:0]  SCAN_LAST  = SW'(DIV - 1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);
  localparam logic [DWW-1:0] DWELL_MAX  = DWW'(DWELL);
  localparam logic [BW-1:0]  BLANK_LAST = BW'(BLANK - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;          // last owner; also the current owner while in OWN
  logic [DWW-1:0]   dwell_q, dwell_d;
  logic [BW-1:0]    blank_q, blank_d;
  logic [SW-1:0]    scan_cnt_q, scan_cnt_d;
  logic             scan_clk_q, scan_clk_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [31:0]      inp_q, inp_d;
  logic [7:0]       digit_en_q, digit_en_d;
  logic             odp_q, odp_d;
  logic             busy_q, busy_d;

  logic             win_vld;
  logic [1:0]       win_idx;
  logic             owner_req;
  logic             others_req;
  logic             dwell_reached;
  logic             blank_last;
  logic             grant_now;
  logic [1:0]       sel;

  // Round-robin pick: first requester after the last owner, the last owner itself scanned last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    // Scan from farthest to nearest so the nearest requester overwrites and wins.
    for (int k = 4; k >= 1; k--) begin
      if (ssd_arbiter_port_req[ptr_q + 2'(k)]) begin
        win_vld = 1'b1;
        win_idx = ptr_q + 2'(k);
      end
    end
  end

  // Condition flags shared by the next-state and output logic.
  always_comb begin
    owner_req  = ssd_arbiter_port_req[ptr_q];
    others_req = |(ssd_arbiter_port_req & ~(4'b0001 << ptr_q));
    // Counts the current OWN cycle too, so the owner leaves after exactly DWELL grant cycles.
    dwell_reached = (dwell_q >= DWELL_LAST);
    blank_last    = (blank_q == BLANK_LAST);
    grant_now     = win_vld &&
                    ((state_q == ST_IDLE) || ((state_q == ST_BLANK) && blank_last));
  end

  // FSM state register; reset drops any grant at once, without a guard interval.
  always_ff @(posedge ssd_arbiter_clk) begin
    if (ssd_arbiter_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: owner drop and dwell expiry both lead to a single BLANK entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!owner_req || (dwell_reached && others_req)) begin
          state_d = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (blank_last) begin
          state_d = win_vld ? ST_OWN : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: mirror the chosen source's display fields while owning, blank otherwise.
  always_comb begin
    sel        = grant_now ? win_idx : ptr_q;
    gnt_d      = 4'b0000;
    inp_d      = 32'h0;
    digit_en_d = 8'h00;
    odp_d      = 1'b0;
    if (state_d == ST_OWN) begin
      gnt_d      = 4'b0001 << sel;
      inp_d      = ssd_arbiter_port_data[{sel, 5'd0} +: 32];
      digit_en_d = ssd_arbiter_port_en[{sel, 3'd0} +: 8];
      odp_d      = ssd_arbiter_port_dp[sel];
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Pointer, dwell and guard-interval counters.
  always_comb begin
    ptr_d = grant_now ? win_idx : ptr_q;

    dwell_d = dwell_q;
    if (grant_now) begin
      dwell_d = '0;
    end else if ((state_q == ST_OWN) && (dwell_q != DWELL_MAX)) begin
      dwell_d = dwell_q + 1'b1;
    end

    // Cleared whenever not blanking so each guard interval starts from zero.
    blank_d = '0;
    if ((state_q == ST_BLANK) && !blank_last) begin
      blank_d = blank_q + 1'b1;
    end
  end

  // Free-running scan-clock divider, independent of arbitration.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_clk_d = scan_clk_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_clk_d = ~scan_clk_q;
    end
  end

  // Arbitration bookkeeping registers.
  always_ff @(posedge ssd_arbiter_clk) begin
    if (ssd_arbiter_rst) begin
      ptr_q   <= 2'd3;
      dwell_q <= '0;
      blank_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      blank_q <= blank_d;
    end
  end

  // Scan-clock registers.
  always_ff @(posedge ssd_arbiter_clk) begin
    if (ssd_arbiter_rst) begin
      scan_cnt_q <= '0;
      scan_clk_q <= 1'b0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_clk_q <= scan_clk_d;
    end
  end

  // Registered outputs to the display driver.
  always_ff @(posedge ssd_arbiter_clk) begin
    if (ssd_arbiter_rst) begin
      gnt_q      <= 4'b0000;
      inp_q      <= 32'h0;
      digit_en_q <= 8'h00;
      odp_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      inp_q      <= inp_d;
      digit_en_q <= digit_en_d;
      odp_q      <= odp_d;
      busy_q     <= busy_d;
    end
  end

  assign ssd_arbiter_port_gnt      = gnt_q;
  assign ssd_arbiter_port_inp      = inp_q;
  assign ssd_arbiter_port_digit_en = digit_en_q;
  assign ssd_arbiter_port_odp      = odp_q;
  assign ssd_arbiter_port_scan_clk = scan_clk_q;
  assign ssd_arbiter_port_busy     = busy_q;

endmodule

// File: tb/tb_ssd_arbiter.sv
// Bench for ssd_arbiter: directed scenarios with literal expectations plus random traffic.
// Inputs change on the falling edge; a reference model steps on the rising edge.
// Every falling edge compares all DUT outputs against the model.
module tb_ssd_arbiter;

  localparam int DIV   = 4;
  localparam int DWELL = 8;
  localparam int BLANK = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] data;
  logic [31:0]  en;
  logic [3:0]   dp;
  logic [3:0]   gnt;
  logic [31:0]  inp;
  logic [7:0]   digit_en;
  logic         odp;
  logic         scan_clk;
  logic         busy;

  int checks = 0;
  int errors = 0;

  ssd_arbiter #(.DIV(DIV), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .ssd_arbiter_clk          (clk),
    .ssd_arbiter_rst          (rst),
    .ssd_arbiter_port_req     (req),
    .ssd_arbiter_port_data    (data),
    .ssd_arbiter_port_en      (en),
    .ssd_arbiter_port_dp      (dp),
    .ssd_arbiter_port_gnt     (gnt),
    .ssd_arbiter_port_inp     (inp),
    .ssd_arbiter_port_digit_en(digit_en),
    .ssd_arbiter_port_odp     (odp),
    .ssd_arbiter_port_scan_clk(scan_clk),
    .ssd_arbiter_port_busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the display, how long it has owned, guard cycles left.
  int          m_owner = -1;
  int          m_own_cycles = 0;
  int          m_blank_left = 0;
  int          m_last = 3;
  int          m_scan_n = 0;
  bit          m_valid = 1'b0;
  logic [3:0]  e_gnt;
  logic [31:0] e_inp;
  logic [7:0]  e_en;
  logic        e_dp;
  logic        e_scan;
  logic        e_busy;

  task automatic model_pick();
    bit found;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_last + k) % 4;
      if (!found && req[idx]) begin
        found        = 1'b1;
        m_owner      = idx;
        m_last       = idx;
        m_own_cycles = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    logic [3:0] others;
    if (rst) begin
      m_owner      = -1;
      m_own_cycles = 0;
      m_blank_left = 0;
      m_last       = 3;
      m_scan_n     = 0;
      m_valid      = 1'b1;
    end else begin
      m_scan_n++;
      if (m_owner >= 0) begin
        m_own_cycles++;
        others = req & ~(4'b0001 << m_owner);
        if (!req[m_owner] || (m_own_cycles >= DWELL && others != 4'b0000)) begin
          m_owner      = -1;
          m_blank_left = BLANK;
        end
      end else if (m_blank_left > 0) begin
        m_blank_left--;
        if (m_blank_left == 0) model_pick();
      end else begin
        model_pick();
      end
    end
    if (m_owner >= 0) begin
      e_gnt = 4'b0001 << m_owner;
      e_inp = data[32*m_owner +: 32];
      e_en  = en[8*m_owner +: 8];
      e_dp  = dp[m_owner];
    end else begin
      e_gnt = 4'b0000;
      e_inp = 32'h0;
      e_en  = 8'h00;
      e_dp  = 1'b0;
    end
    e_scan = ((m_scan_n / DIV) % 2) == 1;
    e_busy = (m_owner >= 0) || (m_blank_left > 0);
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_gnt", {28'h0, gnt}, {28'h0, e_gnt});
      chk("model_inp", inp, e_inp);
      chk("model_digit_en", {24'h0, digit_en}, {24'h0, e_en});
      chk("model_odp", {31'h0, odp}, {31'h0, e_dp});
      chk("model_scan_clk", {31'h0, scan_clk}, {31'h0, e_scan});
      chk("model_busy", {31'h0, busy}, {31'h0, e_busy});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    en   = 32'hFFFFFFFF;
    dp   = 4'b1111;
    tick(3);
    // Reset holds everything low even with all sources requesting.
    chk("rst_gnt", {28'h0, gnt}, 32'h0);
    chk("rst_inp", inp, 32'h0);
    chk("rst_digit_en", {24'h0, digit_en}, 32'h0);
    chk("rst_odp", {31'h0, odp}, 32'h0);
    chk("rst_scan", {31'h0, scan_clk}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);

    // Scan clock: rises after edge 4, falls after edge 8, rises again after edge 12.
    rst = 1'b0;
    req = 4'b0000;
    tick(3);
    chk("scan_before_rise", {31'h0, scan_clk}, 32'h0);
    tick(1);
    chk("scan_rise", {31'h0, scan_clk}, 32'h1);
    tick(3);
    chk("scan_high", {31'h0, scan_clk}, 32'h1);
    tick(1);
    chk("scan_fall", {31'h0, scan_clk}, 32'h0);
    tick(4);
    chk("scan_period", {31'h0, scan_clk}, 32'h1);

    // Single requester keeps the display indefinitely and tracks its data.
    data[63:32] = 32'h12345678;
    en[15:8]    = 8'h0F;
    dp          = 4'b0010;
    req         = 4'b0010;
    tick(1);
    chk("single_gnt", {28'h0, gnt}, 32'h2);
    chk("single_inp", inp, 32'h12345678);
    chk("single_en", {24'h0, digit_en}, 32'h0F);
    chk("single_dp", {31'h0, odp}, 32'h1);
    chk("single_busy", {31'h0, busy}, 32'h1);
    tick(99);
    chk("single_gnt_c100", {28'h0, gnt}, 32'h2);
    data[63:32] = 32'hCAFE0000;
    tick(1);
    chk("single_inp_follow", inp, 32'hCAFE0000);

    // Contention between sources 0 and 2: 8 granted, 2 blank, alternating.
    en = {8'h00, 8'hAA, 8'h00, 8'hFF};
    do_reset();
    req = 4'b0101;
    for (int i = 0; i < 40; i++) begin
      int p;
      logic [3:0] wg;
      logic [7:0] we;
      tick(1);
      p  = i % 20;
      wg = (p < 8) ? 4'b0001 : (p >= 10 && p < 18) ? 4'b0100 : 4'b0000;
      we = (p < 8) ? 8'hFF : (p >= 10 && p < 18) ? 8'hAA : 8'h00;
      chk("contend_gnt", {28'h0, gnt}, {28'h0, wg});
      chk("contend_digit_en", {24'h0, digit_en}, {24'h0, we});
    end

    // Early drop: source 2 owns, source 3 waits; drop after 3 grant cycles.
    data[127:96] = 32'hDEADBEEF;
    do_reset();
    req = 4'b0100;
    tick(1);
    chk("drop_first_gnt", {28'h0, gnt}, 32'h4);
    req = 4'b1100;
    tick(2);
    req = 4'b1000;
    tick(1);
    chk("drop_gap1", {28'h0, gnt}, 32'h0);
    tick(1);
    chk("drop_gap2", {28'h0, gnt}, 32'h0);
    tick(1);
    chk("drop_next_gnt", {28'h0, gnt}, 32'h8);
    chk("drop_next_inp", inp, 32'hDEADBEEF);

    // All drop: guard interval, then idle; re-request is granted next cycle.
    req = 4'b0000;
    tick(1);
    chk("alldrop_busy1", {31'h0, busy}, 32'h1);
    tick(1);
    chk("alldrop_busy2", {31'h0, busy}, 32'h1);
    tick(1);
    chk("alldrop_idle_busy", {31'h0, busy}, 32'h0);
    chk("alldrop_idle_gnt", {28'h0, gnt}, 32'h0);
    chk("alldrop_idle_inp", inp, 32'h0);
    req = 4'b0001;
    tick(1);
    chk("alldrop_regrant", {28'h0, gnt}, 32'h1);

    // Reset while source 3 owns under full contention.
    do_reset();
    req = 4'b1000;
    tick(1);
    chk("rstmid_own3", {28'h0, gnt}, 32'h8);
    req = 4'b1111;
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("rstmid_gnt", {28'h0, gnt}, 32'h0);
    chk("rstmid_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    req = 4'b0110;
    tick(1);
    chk("rstmid_after_gnt", {28'h0, gnt}, 32'h2);

    // Random traffic: flickering requests, changing data, rare resets.
    for (int c = 0; c < 4000; c++) begin
      data = {$urandom, $urandom, $urandom, $urandom};
      en   = $urandom;
      dp   = 4'($urandom);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      end
      rst = ($urandom_range(599) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
